ntt_start_requester: RTL and testbench

//  Core-side initiator for the NTT start arbitration. It queues start commands

---
 rtl/ntt_pkg.sv | 20 ++
 rtl/ntt_start_requester_if.sv | 37 +++
 rtl/ntt_cmd_fifo.sv | 49 ++++
 rtl/ntt_start_requester.sv | 111 +++++++++++
 tb/tb_ntt_start_requester.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared types and widths for the NTT start arbitration slice.
// Holds the requester FSM state encoding and the wait-counter helper.
package ntt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RUN  = 2'd2
    } ntt_state_t;

    localparam int NTT_MASK_W = 4;
    localparam int NTT_CMD_W  = 32;
    localparam int NTT_WAIT_W = 8;

    // Saturating increment so a long-starved request never wraps back to "not starved".
    function automatic logic [NTT_WAIT_W-1:0] sat_inc(input logic [NTT_WAIT_W-1:0] v);
        return (v == '1) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ntt_start_requester_if.sv
// Bundle of sequencer, arbiter and core signals around one NTT start requester.
// The slave modport is the requester; the master modport is its environment.
interface ntt_start_requester_if #(
    parameter int DEPTH  = 4,
    parameter int CMD_W  = ntt_pkg::NTT_CMD_W,
    parameter int MASK_W = ntt_pkg::NTT_MASK_W
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_data;
    logic [MASK_W-1:0] cmd_mask;
    logic              start_req;
    logic [MASK_W-1:0] bank_mask;
    logic              grant_start;
    logic              busy;
    logic              core_start;
    logic [CMD_W-1:0]  core_cmd;
    logic              core_done;
    logic [CNT_W-1:0]  q_count;
    logic              starved;
    logic              err_done;

    modport master (
        output cmd_valid, cmd_data, cmd_mask, grant_start, core_done,
        input  cmd_ready, start_req, bank_mask, busy, core_start, core_cmd,
               q_count, starved, err_done
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_mask, grant_start, core_done,
        output cmd_ready, start_req, bank_mask, busy, core_start, core_cmd,
               q_count, starved, err_done
    );

endinterface

// File: rtl/ntt_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; head is read combinationally.
// Push when full and pop when empty are ignored so the count can never run away.
module ntt_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign wr_en   = push && (count != CNT_W'(DEPTH));
    assign rd_en   = pop && (count != '0);
    assign rd_data = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ntt_start_requester.sv
// Core-side initiator: queues start commands, requests the shared start arbiter,
// launches the NTT core on grant and reports busy until the core signals done.
module ntt_start_requester
    import ntt_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CMD_W        = NTT_CMD_W,
    parameter int MASK_W       = NTT_MASK_W,
    parameter int STARVE_LIMIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    ntt_start_requester_if.slave bus
);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = CMD_W + MASK_W;

    ntt_state_t          state;
    ntt_state_t          state_next;
    logic                push;
    logic                pop;
    logic                cmd_ready;
    logic [CNT_W-1:0]    q_count;
    logic [CNT_W-1:0]    count_after;
    logic [ENTRY_W-1:0]  head;
    logic [CMD_W-1:0]    head_data;
    logic [MASK_W-1:0]   head_mask;
    logic [NTT_WAIT_W-1:0] wait_cnt;
    logic                core_start_q;
    logic [CMD_W-1:0]    core_cmd_q;
    logic                err_done_q;
    logic                start_req_d;
    logic                busy_d;
    logic [MASK_W-1:0]   bank_mask_d;

    assign cmd_ready   = (q_count < CNT_W'(DEPTH));
    assign push        = bus.cmd_valid & cmd_ready;
    assign pop         = (state == REQ) & bus.grant_start;
    assign {head_data, head_mask} = head;
    assign count_after = q_count + CNT_W'(push) - CNT_W'(pop);

    ntt_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data ({bus.cmd_data, bus.cmd_mask}),
        .pop     (pop),
        .rd_data (head),
        .count   (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A finishing run goes straight back to REQ when work is waiting, avoiding an IDLE bubble.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (q_count != '0) state_next = REQ;
            REQ:     if (bus.grant_start) state_next = RUN;
            RUN:     if (bus.core_done) state_next = (count_after != '0) ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Arbiter-facing outputs depend only on registered state, never on grant_start.
    always_comb begin
        start_req_d = 1'b0;
        busy_d      = 1'b0;
        bank_mask_d = '0;
        unique case (state)
            REQ: begin
                start_req_d = 1'b1;
                bank_mask_d = head_mask;
            end
            RUN:     busy_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_start_q <= 1'b0;
            core_cmd_q   <= '0;
            wait_cnt     <= '0;
            err_done_q   <= 1'b0;
        end else begin
            core_start_q <= pop;
            if (pop) core_cmd_q <= head_data;
            if ((state == REQ) && !bus.grant_start) wait_cnt <= sat_inc(wait_cnt);
            else                                    wait_cnt <= '0;
            if (bus.core_done && (state != RUN)) err_done_q <= 1'b1;
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.start_req  = start_req_d;
    assign bus.bank_mask  = bank_mask_d;
    assign bus.busy       = busy_d;
    assign bus.core_start = core_start_q;
    assign bus.core_cmd   = core_cmd_q;
    assign bus.q_count    = q_count;
    assign bus.starved    = (wait_cnt >= NTT_WAIT_W'(STARVE_LIMIT));
    assign bus.err_done   = err_done_q;

endmodule

// File: tb/tb_ntt_start_requester.sv
// Directed bench for ntt_start_requester; launched payloads are checked against
// a FIFO-order scoreboard filled as commands are offered.
module tb_ntt_start_requester;
    import ntt_pkg::*;

    localparam int DEPTH  = 4;
    localparam int CMD_W  = 32;
    localparam int MASK_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   errors   = 0;
    int   launches = 0;
    logic [CMD_W-1:0] sb [$];

    always #5 clk = ~clk;

    ntt_start_requester_if #(.DEPTH(DEPTH), .CMD_W(CMD_W), .MASK_W(MASK_W)) bus ();

    ntt_start_requester #(
        .DEPTH        (DEPTH),
        .CMD_W        (CMD_W),
        .MASK_W       (MASK_W),
        .STARVE_LIMIT (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [CMD_W-1:0] data,
                                 input logic [MASK_W-1:0] mask, input logic grant, input logic done);
        bus.cmd_valid   = valid;
        bus.cmd_data    = data;
        bus.cmd_mask    = mask;
        bus.grant_start = grant;
        bus.core_done   = done;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_start_req"},  bus.start_req,  1'b0);
        checkOutput({tag, "_bank_mask"},  bus.bank_mask,  4'b0000);
        checkOutput({tag, "_busy"},       bus.busy,       1'b0);
        checkOutput({tag, "_core_start"}, bus.core_start, 1'b0);
        checkOutput({tag, "_core_cmd"},   bus.core_cmd,   32'h0);
        checkOutput({tag, "_q_count"},    bus.q_count,    3'd0);
        checkOutput({tag, "_starved"},    bus.starved,    1'b0);
        checkOutput({tag, "_err_done"},   bus.err_done,   1'b0);
        checkOutput({tag, "_cmd_ready"},  bus.cmd_ready,  1'b1);
    endtask

    // Every launch pulse must carry the oldest outstanding command.
    always @(negedge clk) begin
        if (bus.core_start === 1'b1) begin
            launches++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL core_cmd_unexpected observed=0x%0h expected=no_launch", bus.core_cmd);
            end else begin
                checkOutput("core_cmd", bus.core_cmd, sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        checkReset("reset");

        // single command with grant tied high
        applyStimulus(1'b1, 32'hA5A5_0001, 4'b0011, 1'b1, 1'b0);
        sb.push_back(32'hA5A5_0001);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("t1_q_after_push", bus.q_count, 3'd1);
        checkOutput("t1_req_not_yet", bus.start_req, 1'b0);
        tick();
        checkOutput("t1_start_req", bus.start_req, 1'b1);
        checkOutput("t1_bank_mask", bus.bank_mask, 4'b0011);
        checkOutput("t1_no_start_yet", bus.core_start, 1'b0);
        tick();
        checkOutput("t1_core_start", bus.core_start, 1'b1);
        checkOutput("t1_busy", bus.busy, 1'b1);
        checkOutput("t1_req_dropped", bus.start_req, 1'b0);
        checkOutput("t1_q_empty", bus.q_count, 3'd0);
        tick();
        checkOutput("t1_start_one_cycle", bus.core_start, 1'b0);
        checkOutput("t1_busy_held", bus.busy, 1'b1);
        checkOutput("t1_core_cmd_held", bus.core_cmd, 32'hA5A5_0001);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t1_busy_done", bus.busy, 1'b0);
        checkOutput("t1_idle_no_req", bus.start_req, 1'b0);
        checkOutput("t1_no_err", bus.err_done, 1'b0);

        // fill the FIFO with grant low
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'hB000_0000 + i, MASK_W'(1 << i), 1'b0, 1'b0);
            sb.push_back(32'hB000_0000 + i);
            tick();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t2_q_full", bus.q_count, 3'd4);
        checkOutput("t2_not_ready", bus.cmd_ready, 1'b0);
        checkOutput("t2_start_req", bus.start_req, 1'b1);
        checkOutput("t2_bank_mask", bus.bank_mask, 4'b0001);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t2_fifth_rejected", bus.q_count, 3'd4);
        repeat (11) tick();
        checkOutput("t2_not_starved_14", bus.starved, 1'b0);
        checkOutput("t2_mask_stable", bus.bank_mask, 4'b0001);
        tick();
        checkOutput("t2_starved_15", bus.starved, 1'b1);

        // starvation clears after the grant
        repeat (5) tick();
        checkOutput("t3_starved_20", bus.starved, 1'b1);
        checkOutput("t3_still_req", bus.start_req, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t3_starved_clear", bus.starved, 1'b0);
        checkOutput("t3_one_pop", bus.q_count, 3'd3);
        checkOutput("t3_busy", bus.busy, 1'b1);
        checkOutput("t3_core_start", bus.core_start, 1'b1);

        // done with work queued: back to REQ without an IDLE bubble
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t4_req_next", bus.start_req, 1'b1);
        checkOutput("t4_not_busy", bus.busy, 1'b0);
        checkOutput("t4_mask_next", bus.bank_mask, 4'b0010);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t4_q_after_grant", bus.q_count, 3'd2);

        // push and pop on the same edge, then drain through the wrapped pointers
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        checkOutput("t5_mask_b2", bus.bank_mask, 4'b0100);
        applyStimulus(1'b1, 32'hC000_0005, 4'b0101, 1'b1, 1'b0);
        sb.push_back(32'hC000_0005);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t5_q_unchanged", bus.q_count, 3'd2);
        checkOutput("t5_busy", bus.busy, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        checkOutput("t5_mask_b3", bus.bank_mask, 4'b1000);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("t5_q_one", bus.q_count, 3'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        checkOutput("t5_mask_wrapped", bus.bank_mask, 4'b0101);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t5_q_drained", bus.q_count, 3'd0);

        // reset while running with three commands queued
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'hD000_0000 + i, 4'b1111, 1'b0, 1'b0);
            sb.push_back(32'hD000_0000 + i);
            tick();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t6_busy_before", bus.busy, 1'b1);
        checkOutput("t6_q_before", bus.q_count, 3'd3);
        rst = 1'b1;
        tick();
        checkReset("t6_reset");
        rst = 1'b0;
        sb.delete();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t6_err_done", bus.err_done, 1'b1);
        tick();
        checkOutput("t6_err_sticky", bus.err_done, 1'b1);
        checkOutput("t6_idle_after", bus.start_req, 1'b0);

        checkOutput("launch_count", launches, 6);
        checkOutput("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
